clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Core-local interruptor for a single-hart RV32 core.
- Holds the machine software-interrupt bit (msip), the 64-bit machine timer (mtime) and the timer compare register (mtimecmp).
- Drives msip/mtip interrupt lines and the live mtime value to the CPU.
- Sits on the shared memory bus behind the SoC address decoder, which strips the region base, so all addresses below are offsets.

Parameters:
- CLK_DIVIDER, 1, clock cycles per mtime increment (>=1).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clint_valid  input  1  request strobe; one request per cycle it is high
- clint_instr  input  1  instruction-fetch flag; ignored
- clint_addr  input  32  byte offset within CLINT region
- clint_wdata  input  32  write data
- clint_wstrb  input  4  byte write enables; 0 = read
- clint_rdata  output  32  read data, valid while clint_ready=1
- clint_ready  output  1  response strobe
- clint_msip  output  1  software interrupt pending
- clint_mtip  output  1  timer interrupt pending
- clint_mtime  output  64  current mtime

Behaviour:
- Register map (word aligned; addr[1:0] ignored; only addr[15:0] decoded):
  - 0x0000 msip: bit0 R/W, bits 31:1 read 0
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset reads 0; writes to it are ignored, but the access is still acknowledged.
- Reset (reset=0, asynchronous):
  - msip=0, mtime=0, mtimecmp=all ones, prescaler=0
  - clint_ready=0, clint_rdata=0, clint_mtip=0
- Handshake:
  - Request is sampled on a rising edge with clint_valid=1.
  - clint_ready=1 for exactly the following cycle.
  - Fixed latency 1, no wait states, no error response.
  - Back-to-back valid cycles produce back-to-back ready pulses.
  - clint_rdata=0 whenever clint_ready=0.
- Reads:
  - rdata is the register value at the sampling edge, i.e. before that edge's increment or write.
  - Reading mtime lo then hi is not atomic; software handles carry.
- Writes:
  - Each byte lane with wstrb[i]=1 updates bits 8i+7:8i of the addressed word; other lanes are unchanged.
  - For msip, only lane 0 bit0 matters.
  - A write returns the ready pulse with rdata=0.
- mtime:
  - Prescaler counts 0..CLK_DIVIDER-1; mtime increments by 1 on the wrap cycle.
  - mtime wraps from 2^64-1 to 0.
  - A bus write to either mtime half on the same edge as an increment takes priority: the written bytes are loaded, and the unwritten bytes keep the old value with no increment applied.
- mtip:
  - Registered: mtip = (mtime >= mtimecmp), 64-bit unsigned compare, evaluated from the register values after each edge.
  - mtip therefore reflects a new mtimecmp or mtime one cycle after the write edge.
- clint_msip is a direct register output; clint_mtime is the mtime register.
- Reset asserted mid-transaction aborts it: no ready pulse; the outstanding response is dropped.

Test Plan:
- Reset then release, idle 10 cycles (CLK_DIVIDER=1) -> clint_mtime=10, mtip=0, msip=0, ready never asserted.
- Write 0x1 to 0x0000 with wstrb=0001, then read 0x0000 -> ready one cycle after each request; msip=1; read rdata=0x00000001. Write 0 -> msip=0.
- Write mtimecmp: hi=0 at 0x4004, then lo=0x40 at 0x4000 -> mtip rises in the cycle after mtime reaches 0x40. Rewrite hi=1 -> mtip falls one cycle later.
- Write mtime lo=0xFFFFFFFE, hi=0 -> two increments later, mtime hi reads 1 and lo reads 0 (carry propagation verified).
- Byte-strobe write 0xAABBCCDD to 0x4000 with wstrb=0100 -> mtimecmp lo=0xFFBBFFFF.
- Read unmapped offset 0x1234; also valid held high 3 cycles -> rdata=0; three consecutive ready pulses. Assert reset during a request -> no ready pulse; all registers return to reset values.

Source files
------------

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, 64-bit mtime with prescaler, mtimecmp.
// Single-cycle bus responder with registered read data and mtip.
module clint_timer #(
  parameter int unsigned CLK_DIVIDER = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  localparam int unsigned PW =
    (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          msip;
  logic          mtip;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          ready;
  logic [31:0]   rdata;
  logic [31:0]   rmux;
  logic [13:0]   word;
  logic          wr;
  logic          rd;
  logic          sel_msip;
  logic          sel_cmp_lo;
  logic          sel_cmp_hi;
  logic          sel_mt_lo;
  logic          sel_mt_hi;
  logic          unused;

  assign unused = ^{clint_addr[31:16], clint_addr[1:0], clint_instr};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  assign tick = (presc == PW'(CLK_DIVIDER - 1));

  assign word       = clint_addr[15:2];
  assign sel_msip   = (word == 14'h0000);
  assign sel_cmp_lo = (word == 14'h1000);
  assign sel_cmp_hi = (word == 14'h1001);
  assign sel_mt_lo  = (word == 14'h2FFE);
  assign sel_mt_hi  = (word == 14'h2FFF);

  assign wr = clint_valid && (clint_wstrb != 4'b0000);
  assign rd = clint_valid && (clint_wstrb == 4'b0000);

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_msip:   rmux = {31'b0, msip};
      sel_cmp_lo: rmux = mtimecmp[31:0];
      sel_cmp_hi: rmux = mtimecmp[63:32];
      sel_mt_lo:  rmux = mtime[31:0];
      sel_mt_hi:  rmux = mtime[63:32];
      default:    rmux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      msip     <= 1'b0;
      mtip     <= 1'b0;
      mtime    <= '0;
      mtimecmp <= '1;
      ready    <= 1'b0;
      rdata    <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // A bus write to mtime suppresses this edge's increment entirely
      if (wr && (sel_mt_lo || sel_mt_hi)) begin
        if (sel_mt_lo)
          mtime[31:0] <= merge(mtime[31:0], clint_wdata, clint_wstrb);
        if (sel_mt_hi)
          mtime[63:32] <= merge(mtime[63:32], clint_wdata, clint_wstrb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr && sel_msip && clint_wstrb[0])
        msip <= clint_wdata[0];
      if (wr && sel_cmp_lo)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], clint_wdata, clint_wstrb);
      if (wr && sel_cmp_hi)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], clint_wdata, clint_wstrb);
      mtip  <= (mtime >= mtimecmp);
      ready <= clint_valid;
      rdata <= rd ? rmux : '0;
    end
  end

  assign clint_rdata = rdata;
  assign clint_ready = ready;
  assign clint_msip  = msip;
  assign clint_mtip  = mtip;
  assign clint_mtime = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: register map, handshake,
// mtime carry, byte strobes, mtip timing and mid-request reset.
module tb_clint_timer;

  logic        clock;
  logic        reset;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        clint_msip;
  logic        clint_mtip;
  logic [63:0] clint_mtime;

  int n_checks = 0;
  int n_fail   = 0;

  clint_timer #(.CLK_DIVIDER(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .clint_valid (clint_valid),
    .clint_instr (clint_instr),
    .clint_addr  (clint_addr),
    .clint_wdata (clint_wdata),
    .clint_wstrb (clint_wstrb),
    .clint_rdata (clint_rdata),
    .clint_ready (clint_ready),
    .clint_msip  (clint_msip),
    .clint_mtip  (clint_mtip),
    .clint_mtime (clint_mtime)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] r
  );
    @(negedge clock);
    clint_valid = 1'b1;
    clint_addr  = a;
    clint_wdata = d;
    clint_wstrb = s;
    @(posedge clock);
    #1;
    clint_valid = 1'b0;
    clint_wstrb = 4'b0000;
    check("ready", {63'b0, clint_ready}, 64'd1);
    r = clint_rdata;
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    bus(a, d, s, r);
    check("wr_rdata", {32'b0, r}, 64'd0);
  endtask

  task automatic rd(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    logic [31:0] r;
    bus(a, 32'h0, 4'b0000, r);
    check(tag, {32'b0, r}, {32'b0, exp});
  endtask

  initial begin
    logic seen;
    reset       = 1'b0;
    clint_valid = 1'b0;
    clint_instr = 1'b0;
    clint_addr  = '0;
    clint_wdata = '0;
    clint_wstrb = '0;
    #1;
    check("rst_ready", {63'b0, clint_ready}, 64'd0);
    check("rst_rdata", {32'b0, clint_rdata}, 64'd0);
    check("rst_mtime", clint_mtime, 64'd0);
    check("rst_mtip", {63'b0, clint_mtip}, 64'd0);

    // idle after release: one increment per edge
    @(negedge clock);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1;
      seen = seen | clint_ready;
    end
    check("idle_mtime", clint_mtime, 64'd10);
    check("idle_mtip", {63'b0, clint_mtip}, 64'd0);
    check("idle_msip", {63'b0, clint_msip}, 64'd0);
    check("idle_ready", {63'b0, seen}, 64'd0);

    // msip
    wr(32'h0000, 32'h1, 4'b0001);
    check("msip_set", {63'b0, clint_msip}, 64'd1);
    rd("msip_rd", 32'h0000, 32'h1);
    @(posedge clock);
    #1;
    check("ready_drop", {63'b0, clint_ready}, 64'd0);
    check("rdata_idle", {32'b0, clint_rdata}, 64'd0);
    wr(32'h0000, 32'h0, 4'b0001);
    check("msip_clr", {63'b0, clint_msip}, 64'd0);

    // mtimecmp = 0x40
    wr(32'h4004, 32'h0, 4'b1111);
    wr(32'h4000, 32'h40, 4'b1111);
    for (int i = 0; i < 200 && clint_mtime != 64'd64; i++) begin
      @(posedge clock);
      #1;
    end
    check("mtime_hit", clint_mtime, 64'd64);
    check("mtip_lag", {63'b0, clint_mtip}, 64'd0);
    @(posedge clock);
    #1;
    check("mtip_rise", {63'b0, clint_mtip}, 64'd1);
    wr(32'h4004, 32'h1, 4'b1111);
    check("mtip_hold", {63'b0, clint_mtip}, 64'd1);
    @(posedge clock);
    #1;
    check("mtip_fall", {63'b0, clint_mtip}, 64'd0);

    // mtime write and carry into hi word
    wr(32'hBFF8, 32'hFFFF_FFFE, 4'b1111);
    wr(32'hBFFC, 32'h0, 4'b1111);
    check("mt_loaded", clint_mtime, 64'h0000_0000_FFFF_FFFE);
    repeat (2) @(posedge clock);
    #1;
    check("mt_carry", clint_mtime, 64'h0000_0001_0000_0000);
    rd("mt_hi", 32'hBFFC, 32'h1);
    rd("mt_lo", 32'hBFF8, 32'h1);

    // byte strobes
    wr(32'h4000, 32'hFFFF_FFFF, 4'b1111);
    wr(32'h4000, 32'hAABB_CCDD, 4'b0100);
    rd("cmp_lo_byte", 32'h4000, 32'hFFBB_FFFF);
    rd("cmp_hi", 32'h4004, 32'h1);

    // unmapped offset
    rd("unmapped", 32'h1234, 32'h0);
    wr(32'h1234, 32'hFFFF_FFFF, 4'b1111);
    rd("cmp_lo_keep", 32'h4000, 32'hFFBB_FFFF);

    // valid held for three cycles
    @(negedge clock);
    clint_valid = 1'b1;
    clint_addr  = 32'h4004;
    clint_wstrb = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("b2b_ready", {63'b0, clint_ready}, 64'd1);
      check("b2b_rdata", {32'b0, clint_rdata}, 64'd1);
    end
    clint_valid = 1'b0;
    @(posedge clock);
    #1;
    check("b2b_end", {63'b0, clint_ready}, 64'd0);

    // arm msip and mtip, then reset during a request
    wr(32'h0000, 32'h1, 4'b0001);
    wr(32'h4004, 32'h0, 4'b1111);
    @(posedge clock);
    #1;
    check("pre_rst_mtip", {63'b0, clint_mtip}, 64'd1);
    check("pre_rst_msip", {63'b0, clint_msip}, 64'd1);
    @(negedge clock);
    clint_valid = 1'b1;
    clint_addr  = 32'h0000;
    clint_wstrb = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    check("ar_msip", {63'b0, clint_msip}, 64'd0);
    check("ar_mtip", {63'b0, clint_mtip}, 64'd0);
    check("ar_mtime", clint_mtime, 64'd0);
    @(posedge clock);
    #1;
    check("ar_ready", {63'b0, clint_ready}, 64'd0);
    check("ar_rdata", {32'b0, clint_rdata}, 64'd0);
    @(negedge clock);
    clint_valid = 1'b0;
    reset       = 1'b1;
    rd("ar_cmp_lo", 32'h4000, 32'hFFFF_FFFF);
    rd("ar_cmp_hi", 32'h4004, 32'hFFFF_FFFF);
    rd("ar_msip_rd", 32'h0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
